// File: rtl/wbs_axil_bridge_pkg.sv
// ---------------------------------------------------------------------------
// wbs_axil_bridge_pkg
// Shared definitions for the Wishbone-slave to AXI4-Lite-master bridge:
//   - FSM state encoding (legacy-compatible 3-bit constants)
//   - AXI response codes
//   - resp_is_error(): classifies an AXI response as an error completion
// ---------------------------------------------------------------------------
package wbs_axil_bridge_pkg;

  // Bridge FSM state encoding.
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE         = 3'd0;
  localparam state_t ST_WR_ADDR_DATA = 3'd1;
  localparam state_t ST_WR_RESP      = 3'd2;
  localparam state_t ST_RD_ADDR      = 3'd3;
  localparam state_t ST_RD_DATA      = 3'd4;
  localparam state_t ST_DONE         = 3'd5;

  // AXI4-Lite response codes.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // SLVERR and DECERR are errors; OKAY and EXOKAY are normal completions.
  function automatic logic resp_is_error(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/wbs_axil_bridge.sv
// ---------------------------------------------------------------------------
// wbs_axil_bridge
// Pipelined Wishbone slave (one transaction outstanding) driving an AXI4-Lite
// master port. A WB request is latched, the matching AXI transaction is run to
// completion, then a single-cycle ack (or err) is returned on WB.
//
// Optional feature macro: WBS_AXIL_BRIDGE_ERR_EN
//   defined   -> SLVERR/DECERR responses complete with o_wb_err instead of ack
//   undefined -> o_wb_err is tied low and every completion is an ack
//
// Ports:
//   i_clk_100, i_rst_100          clock, synchronous active-high reset
//   i_wb_cyc/stb/we/adr/dat/sel   WB request (adr is a word address)
//   o_wb_stall/ack/err/dat        WB flow control and completion
//   o_axi_AW*/W*/B*               AXI4-Lite write channels
//   o_axi_AR*/R*                  AXI4-Lite read channels
// Every output is driven straight from a register.
// ---------------------------------------------------------------------------
module wbs_axil_bridge
  import wbs_axil_bridge_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int WB_ADDR_WIDTH  = 30,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      i_clk_100,
  input  logic                      i_rst_100,
  input  logic                      i_wb_cyc,
  input  logic                      i_wb_stb,
  input  logic                      i_wb_we,
  input  logic [WB_ADDR_WIDTH-1:0]  i_wb_adr,
  input  logic [31:0]               i_wb_dat,
  input  logic [3:0]                i_wb_sel,
  output logic                      o_wb_stall,
  output logic                      o_wb_ack,
  output logic                      o_wb_err,
  output logic [31:0]               o_wb_dat,
  output logic                      o_axi_AWVALID,
  input  logic                      i_axi_AWREADY,
  output logic [AXI_ADDR_WIDTH-1:0] o_axi_AWADDR,
  output logic [2:0]                o_axi_AWPROT,
  output logic                      o_axi_WVALID,
  input  logic                      i_axi_WREADY,
  output logic [31:0]               o_axi_WDATA,
  output logic [3:0]                o_axi_WSTRB,
  input  logic                      i_axi_BVALID,
  output logic                      o_axi_BREADY,
  input  logic [1:0]                i_axi_BRESP,
  output logic                      o_axi_ARVALID,
  input  logic                      i_axi_ARREADY,
  output logic [AXI_ADDR_WIDTH-1:0] o_axi_ARADDR,
  output logic [2:0]                o_axi_ARPROT,
  input  logic                      i_axi_RVALID,
  output logic                      o_axi_RREADY,
  input  logic [31:0]               i_axi_RDATA,
  input  logic [1:0]                i_axi_RRESP
);

  localparam int BYTE_ADR_W = WB_ADDR_WIDTH + 2;

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("wbs_axil_bridge: DATA_WIDTH must be 32");
  end

  state_t                    state_r;
  state_t                    state_nx_s;
  logic                      abort_r;
  logic                      abort_nx_s;
  logic                      accept_s;
  logic                      aw_left_s;
  logic                      w_left_s;
  logic                      resp_hs_s;
  logic                      resp_err_s;
  logic [1:0]                resp_s;
  logic [BYTE_ADR_W-1:0]     byte_adr_s;
  logic [AXI_ADDR_WIDTH-1:0] axi_adr_s;

  logic                      stall_r;
  logic                      ack_r;
  logic [31:0]               rdat_r;
  logic                      awvalid_r;
  logic                      wvalid_r;
  logic                      bready_r;
  logic                      arvalid_r;
  logic                      rready_r;
  logic [AXI_ADDR_WIDTH-1:0] addr_r;
  logic [31:0]               wdata_r;
  logic [3:0]                wstrb_r;

  // WB word address -> AXI byte address, zero-extended or truncated.
  assign byte_adr_s = {i_wb_adr, 2'b00};
  if (AXI_ADDR_WIDTH > BYTE_ADR_W) begin : g_adr_ext
    assign axi_adr_s = {{(AXI_ADDR_WIDTH - BYTE_ADR_W){1'b0}}, byte_adr_s};
  end else begin : g_adr_trunc
    assign axi_adr_s = byte_adr_s[AXI_ADDR_WIDTH-1:0];
  end

  // A write channel is still owed while its VALID is up without READY.
  assign aw_left_s = awvalid_r & ~i_axi_AWREADY;
  assign w_left_s  = wvalid_r & ~i_axi_WREADY;

  // Response code of whichever response channel is active this cycle.
  assign resp_s = (state_r == ST_WR_RESP) ? i_axi_BRESP : i_axi_RRESP;

`ifdef WBS_AXIL_BRIDGE_ERR_EN
  assign resp_err_s = resp_is_error(resp_s);
`else
  logic unused_resp_s;
  assign resp_err_s    = 1'b0;
  assign unused_resp_s = ^resp_s;
`endif

  // Next-state logic, request acceptance and abort tracking.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    resp_hs_s  = 1'b0;
    // Abort is sticky from the first cycle cyc is seen low while the
    // transaction is still in progress; it only clears back in IDLE.
    if (state_r == ST_IDLE) begin
      abort_nx_s = 1'b0;
    end else if ((state_r != ST_DONE) && !i_wb_cyc) begin
      abort_nx_s = 1'b1;
    end else begin
      abort_nx_s = abort_r;
    end
    case (state_r)
      ST_IDLE: begin
        if (i_wb_cyc && i_wb_stb && !stall_r) begin
          accept_s   = 1'b1;
          state_nx_s = i_wb_we ? ST_WR_ADDR_DATA : ST_RD_ADDR;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_WR_ADDR_DATA: begin
        if (!aw_left_s && !w_left_s) begin
          state_nx_s = ST_WR_RESP;
        end else begin
          state_nx_s = ST_WR_ADDR_DATA;
        end
      end
      ST_WR_RESP: begin
        if (i_axi_BVALID) begin
          resp_hs_s  = 1'b1;
          // An aborted transaction completes silently straight to IDLE.
          state_nx_s = abort_nx_s ? ST_IDLE : ST_DONE;
        end else begin
          state_nx_s = ST_WR_RESP;
        end
      end
      ST_RD_ADDR: begin
        if (i_axi_ARREADY) begin
          state_nx_s = ST_RD_DATA;
        end else begin
          state_nx_s = ST_RD_ADDR;
        end
      end
      ST_RD_DATA: begin
        if (i_axi_RVALID) begin
          resp_hs_s  = 1'b1;
          state_nx_s = abort_nx_s ? ST_IDLE : ST_DONE;
        end else begin
          state_nx_s = ST_RD_DATA;
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State, handshake outputs and WB completion, all registered from next state.
  always_ff @(posedge i_clk_100) begin
    if (i_rst_100) begin
      state_r   <= ST_IDLE;
      abort_r   <= 1'b0;
      stall_r   <= 1'b0;
      awvalid_r <= 1'b0;
      wvalid_r  <= 1'b0;
      bready_r  <= 1'b0;
      arvalid_r <= 1'b0;
      rready_r  <= 1'b0;
      ack_r     <= 1'b0;
      rdat_r    <= 32'h0;
    end else begin
      state_r   <= state_nx_s;
      abort_r   <= abort_nx_s;
      stall_r   <= (state_nx_s != ST_IDLE);
      // AW and W rise together after accept and drop on their own handshakes.
      awvalid_r <= (accept_s & i_wb_we) | ((state_r == ST_WR_ADDR_DATA) & aw_left_s);
      wvalid_r  <= (accept_s & i_wb_we) | ((state_r == ST_WR_ADDR_DATA) & w_left_s);
      arvalid_r <= (state_nx_s == ST_RD_ADDR);
      bready_r  <= (state_nx_s == ST_WR_RESP);
      rready_r  <= (state_nx_s == ST_RD_DATA);
      ack_r     <= resp_hs_s & ~abort_nx_s & ~resp_err_s;
      // Read data is only presented during the ack cycle; zero otherwise.
      if (resp_hs_s && !abort_nx_s && (state_r == ST_RD_DATA)) begin
        rdat_r <= i_axi_RDATA;
      end else begin
        rdat_r <= 32'h0;
      end
    end
  end

  // Request payload, captured on accept and held stable for the AXI channels.
  always_ff @(posedge i_clk_100) begin
    if (i_rst_100) begin
      addr_r  <= '0;
      wdata_r <= 32'h0;
      wstrb_r <= 4'h0;
    end else if (accept_s) begin
      addr_r  <= axi_adr_s;
      wdata_r <= i_wb_dat;
      wstrb_r <= i_wb_sel;
    end else begin
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
      wstrb_r <= wstrb_r;
    end
  end

`ifdef WBS_AXIL_BRIDGE_ERR_EN
  logic err_r;

  // Error completion pulse for SLVERR/DECERR responses.
  always_ff @(posedge i_clk_100) begin
    if (i_rst_100) begin
      err_r <= 1'b0;
    end else begin
      err_r <= resp_hs_s & ~abort_nx_s & resp_err_s;
    end
  end

  assign o_wb_err = err_r;
`else
  assign o_wb_err = 1'b0;
`endif

  assign o_wb_stall    = stall_r;
  assign o_wb_ack      = ack_r;
  assign o_wb_dat      = rdat_r;
  assign o_axi_AWVALID = awvalid_r;
  assign o_axi_AWADDR  = addr_r;
  assign o_axi_AWPROT  = 3'b000;
  assign o_axi_WVALID  = wvalid_r;
  assign o_axi_WDATA   = wdata_r;
  assign o_axi_WSTRB   = wstrb_r;
  assign o_axi_BREADY  = bready_r;
  assign o_axi_ARVALID = arvalid_r;
  assign o_axi_ARADDR  = addr_r;
  assign o_axi_ARPROT  = 3'b000;
  assign o_axi_RREADY  = rready_r;

endmodule

// File: tb/tb_wbs_axil_bridge.sv
// ---------------------------------------------------------------------------
// tb_wbs_axil_bridge
// Bench for wbs_axil_bridge: directed scenarios with literal expectations,
// then randomized WB master / AXI slave traffic compared every cycle against
// a transaction-level model of what the bridge owes on each channel.
// ---------------------------------------------------------------------------
module tb_wbs_axil_bridge;

`ifdef WBS_AXIL_BRIDGE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [29:0] adr = 30'h0;
  logic [31:0] dat = 32'h0;
  logic [3:0]  sel = 4'h0;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic        arready = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic [31:0] rdata = 32'h0;

  logic        o_wb_stall, o_wb_ack, o_wb_err;
  logic [31:0] o_wb_dat;
  logic        o_axi_AWVALID, o_axi_WVALID, o_axi_BREADY, o_axi_ARVALID, o_axi_RREADY;
  logic [31:0] o_axi_AWADDR, o_axi_ARADDR, o_axi_WDATA;
  logic [2:0]  o_axi_AWPROT, o_axi_ARPROT;
  logic [3:0]  o_axi_WSTRB;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  wbs_axil_bridge dut (
    .i_clk_100(clk), .i_rst_100(rst),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_adr(adr),
    .i_wb_dat(dat), .i_wb_sel(sel),
    .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err), .o_wb_dat(o_wb_dat),
    .o_axi_AWVALID(o_axi_AWVALID), .i_axi_AWREADY(awready),
    .o_axi_AWADDR(o_axi_AWADDR), .o_axi_AWPROT(o_axi_AWPROT),
    .o_axi_WVALID(o_axi_WVALID), .i_axi_WREADY(wready),
    .o_axi_WDATA(o_axi_WDATA), .o_axi_WSTRB(o_axi_WSTRB),
    .i_axi_BVALID(bvalid), .o_axi_BREADY(o_axi_BREADY), .i_axi_BRESP(bresp),
    .o_axi_ARVALID(o_axi_ARVALID), .i_axi_ARREADY(arready),
    .o_axi_ARADDR(o_axi_ARADDR), .o_axi_ARPROT(o_axi_ARPROT),
    .i_axi_RVALID(rvalid), .o_axi_RREADY(o_axi_RREADY),
    .i_axi_RDATA(rdata), .i_axi_RRESP(rresp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: what the bridge still owes on each channel.
  logic        m_busy = 1'b0, m_we = 1'b0, m_aw = 1'b0, m_w = 1'b0, m_ar = 1'b0;
  logic        m_rsp = 1'b0, m_done = 1'b0, m_abort = 1'b0;
  logic [31:0] m_addr = 32'h0, m_wdat = 32'h0;
  logic [3:0]  m_sel = 4'h0;
  logic        e_ack = 1'b0, e_err = 1'b0;
  logic [31:0] e_dat = 32'h0;

  task automatic model_step();
    logic [1:0] resp;
    if (rst) begin
      m_busy = 1'b0; m_aw = 1'b0; m_w = 1'b0; m_ar = 1'b0; m_rsp = 1'b0;
      m_done = 1'b0; m_abort = 1'b0; e_ack = 1'b0; e_err = 1'b0; e_dat = 32'h0;
      return;
    end
    e_ack = 1'b0; e_err = 1'b0; e_dat = 32'h0;
    if (m_done) begin
      m_done = 1'b0;
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (cyc && stb) begin
        m_busy = 1'b1; m_we = we; m_addr = {adr, 2'b00}; m_wdat = dat; m_sel = sel;
        m_abort = 1'b0;
        if (we) begin m_aw = 1'b1; m_w = 1'b1; end
        else m_ar = 1'b1;
      end
    end else begin
      if (!cyc) m_abort = 1'b1;
      if (m_aw || m_w) begin
        if (m_aw && awready) m_aw = 1'b0;
        if (m_w && wready) m_w = 1'b0;
        if (!m_aw && !m_w) m_rsp = 1'b1;
      end else if (m_ar) begin
        if (arready) begin m_ar = 1'b0; m_rsp = 1'b1; end
      end else if (m_rsp && (m_we ? bvalid : rvalid)) begin
        resp  = m_we ? bresp : rresp;
        m_rsp = 1'b0;
        if (m_abort) m_busy = 1'b0;
        else begin
          m_done = 1'b1;
          e_err  = ERR_EN && resp[1];
          e_ack  = !e_err;
          e_dat  = m_we ? 32'h0 : rdata;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("stall",   64'(o_wb_stall),    64'(m_busy));
      chk("ack",     64'(o_wb_ack),      64'(e_ack));
      chk("err",     64'(o_wb_err),      64'(e_err));
      chk("rdat",    64'(o_wb_dat),      64'(e_dat));
      chk("awvalid", 64'(o_axi_AWVALID), 64'(m_aw));
      chk("wvalid",  64'(o_axi_WVALID),  64'(m_w));
      chk("arvalid", 64'(o_axi_ARVALID), 64'(m_ar));
      chk("bready",  64'(o_axi_BREADY),  64'(m_rsp & m_we));
      chk("rready",  64'(o_axi_RREADY),  64'(m_rsp & ~m_we));
      chk("awprot",  64'(o_axi_AWPROT),  64'd0);
      chk("arprot",  64'(o_axi_ARPROT),  64'd0);
      if (m_aw) chk("awaddr", 64'(o_axi_AWADDR), 64'(m_addr));
      if (m_w) begin
        chk("wdata", 64'(o_axi_WDATA), 64'(m_wdat));
        chk("wstrb", 64'(o_axi_WSTRB), 64'(m_sel));
      end
      if (m_ar) chk("araddr", 64'(o_axi_ARADDR), 64'(m_addr));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wb_req(input logic w, input logic [29:0] a, input logic [31:0] d, input logic [3:0] s);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
  endtask

  initial begin
    int phase, wait_cnt, acks;
    bit pres_ok;
    repeat (3) tick();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_stall",   64'(o_wb_stall),    64'd0);
    chk("rst_ack",     64'(o_wb_ack),      64'd0);
    chk("rst_awvalid", 64'(o_axi_AWVALID), 64'd0);
    chk("rst_arvalid", 64'(o_axi_ARVALID), 64'd0);
    tick();

    // 1: write, everything ready immediately.
    awready = 1'b1; wready = 1'b1; arready = 1'b1; bvalid = 1'b1; rvalid = 1'b1;
    wb_req(1'b1, 30'h0000_0400, 32'hDEADBEEF, 4'hF);
    tick(); stb = 1'b0;
    chk("d1_awaddr", 64'(o_axi_AWADDR), 64'h0000_1000);
    chk("d1_wdata",  64'(o_axi_WDATA),  64'hDEADBEEF);
    chk("d1_wstrb",  64'(o_axi_WSTRB),  64'hF);
    chk("d1_stall1", 64'(o_wb_stall),   64'd1);
    tick();
    chk("d1_stall2", 64'(o_wb_stall),   64'd1);
    chk("d1_bready", 64'(o_axi_BREADY), 64'd1);
    tick();
    chk("d1_ack",    64'(o_wb_ack),     64'd1);
    chk("d1_stall3", 64'(o_wb_stall),   64'd1);
    cyc = 1'b0;
    tick();
    chk("d1_ack_off", 64'(o_wb_ack),   64'd0);
    chk("d1_idle",    64'(o_wb_stall), 64'd0);

    // 2: read with ARREADY held off for 5 cycles.
    arready = 1'b0; rdata = 32'h1234_5678; rresp = 2'b00;
    wb_req(1'b0, 30'h10, 32'h0, 4'h0);
    tick(); stb = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("d2_arvalid", 64'(o_axi_ARVALID), 64'd1);
      chk("d2_araddr",  64'(o_axi_ARADDR),  64'h40);
      arready = (i == 4);
      tick();
    end
    arready = 1'b0;
    chk("d2_ar_done", 64'(o_axi_ARVALID), 64'd0);
    chk("d2_rready",  64'(o_axi_RREADY),  64'd1);
    tick();
    chk("d2_ack",  64'(o_wb_ack), 64'd1);
    chk("d2_rdat", 64'(o_wb_dat), 64'h1234_5678);
    cyc = 1'b0;
    tick();

    // 3: write where W handshakes 3 cycles before AW.
    awready = 1'b0; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    wb_req(1'b1, 30'h3, 32'hA5A5_0001, 4'h3);
    tick(); stb = 1'b0;
    chk("d3_both_valid", 64'({o_axi_AWVALID, o_axi_WVALID}), 64'h3);
    tick();
    chk("d3_w_dropped", 64'({o_axi_AWVALID, o_axi_WVALID}), 64'h2);
    chk("d3_bready_a",  64'(o_axi_BREADY), 64'd0);
    tick();
    chk("d3_bready_b",  64'(o_axi_BREADY), 64'd0);
    tick();
    chk("d3_bready_c",  64'(o_axi_BREADY), 64'd0);
    awready = 1'b1;
    tick(); awready = 1'b0;
    chk("d3_aw_done", 64'(o_axi_AWVALID), 64'd0);
    chk("d3_bready",  64'(o_axi_BREADY),  64'd1);
    acks = 0;
    repeat (4) begin tick(); acks += int'(o_wb_ack); end
    chk("d3_ack_count", 64'(acks), 64'd1);
    cyc = 1'b0;
    tick();

    // 4: read answered with DECERR.
    arready = 1'b1; rvalid = 1'b1; rresp = 2'b11; rdata = 32'hCAFE_F00D;
    wb_req(1'b0, 30'h20, 32'h0, 4'h0);
    tick(); stb = 1'b0;
    tick(); tick();
    chk("d4_err", 64'(o_wb_err), 64'(ERR_EN));
    chk("d4_ack", 64'(o_wb_ack), 64'(!ERR_EN));
    cyc = 1'b0; rresp = 2'b00;
    tick();

    // 5: cyc dropped while waiting for B; the write still completes silently.
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
    wb_req(1'b1, 30'h55, 32'h0000_5555, 4'h1);
    tick(); stb = 1'b0;
    tick();
    chk("d5_bready_a", 64'(o_axi_BREADY), 64'd1);
    cyc = 1'b0;
    tick();
    chk("d5_bready_b", 64'(o_axi_BREADY), 64'd1);
    bvalid = 1'b1;
    acks = 0;
    repeat (2) begin tick(); acks += int'(o_wb_ack) + int'(o_wb_err); end
    chk("d5_no_cmpl", 64'(acks), 64'd0);
    bvalid = 1'b0; rvalid = 1'b1; rdata = 32'h0BAD_CAFE;
    wb_req(1'b0, 30'h7, 32'h0, 4'h0);
    wait_cnt = 0;
    while (!o_wb_ack && wait_cnt < 20) begin
      tick(); stb = stb & o_wb_stall; wait_cnt++;
    end
    chk("d5_next_ack",  64'(o_wb_ack), 64'd1);
    chk("d5_next_rdat", 64'(o_wb_dat), 64'h0BAD_CAFE);
    cyc = 1'b0; stb = 1'b0;
    tick();

    // 6: reset while ARVALID is high.
    arready = 1'b0;
    wb_req(1'b0, 30'h99, 32'h0, 4'h0);
    tick(); stb = 1'b0;
    chk("d6_arvalid", 64'(o_axi_ARVALID), 64'd1);
    rst = 1'b1; cyc = 1'b0;
    tick();
    chk("d6_rst_outs", 64'({o_wb_stall, o_wb_ack, o_wb_err, o_axi_AWVALID, o_axi_WVALID,
                            o_axi_BREADY, o_axi_ARVALID, o_axi_RREADY}), 64'd0);
    chk("d6_rst_dat",  64'(o_wb_dat),     64'd0);
    chk("d6_rst_addr", 64'(o_axi_ARADDR), 64'd0);
    rst = 1'b0;
    tick();

    // Randomized traffic against the model.
    phase = 0; wait_cnt = 0; pres_ok = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      awready = 1'($urandom_range(0, 1));
      wready  = 1'($urandom_range(0, 1));
      arready = 1'($urandom_range(0, 1));
      bvalid  = ($urandom_range(0, 2) == 0);
      rvalid  = ($urandom_range(0, 2) == 0);
      bresp   = 2'($urandom_range(0, 3));
      rresp   = 2'($urandom_range(0, 3));
      rdata   = $urandom;
      case (phase)
        0: begin
          if ($urandom_range(0, 2) == 0) begin
            wb_req(1'($urandom_range(0, 1)), 30'($urandom), $urandom, 4'($urandom));
            pres_ok = !o_wb_stall; phase = 1; wait_cnt = 0;
          end else begin
            cyc = 1'b0; stb = 1'b0;
          end
        end
        1: begin
          if (pres_ok) begin stb = 1'b0; phase = 2; end
          else pres_ok = !o_wb_stall;
        end
        default: begin
          if (o_wb_ack || o_wb_err) begin cyc = 1'b0; phase = 0; end
          else if ($urandom_range(0, 63) == 0) begin cyc = 1'b0; phase = 0; end
        end
      endcase
      if (phase != 0) wait_cnt++;
      if (wait_cnt > 300) begin
        total++; bad++;
        $display("FAIL wb_timeout: waited %0d cycles, limit 300", wait_cnt);
        break;
      end
      tick();
    end
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
